// File: rtl/pic_pkg.sv
// Shared definitions for the pic_n interrupt controller.
// Register select codes, OCR bit positions, reset constants, rank helper.
package pic_pkg;

    typedef enum logic [1:0] {
        SEL_OCR = 2'd0,
        SEL_IMR = 2'd1,
        SEL_IRR = 2'd2,
        SEL_ISR = 2'd3
    } sel_e;

    localparam int OCR_EOI_BIT = 0;
    localparam int OCR_ROT_BIT = 1;

    // Reset values; IMR resets to all lines masked.
    localparam logic RST_MASK = 1'b1;
    localparam logic RST_INT  = 1'b0;
    localparam logic RST_ROT  = 1'b0;

    // Priority rank of a line: 0 is the highest, the line after ptr.
    function automatic int prio_rank(int idx, int ptr, int n);
        return (idx + n - ptr - 1) % n;
    endfunction

endpackage

// File: rtl/pic_prio_resolve.sv
// Combinational priority resolver: finds the highest-ranked set request.
// Ports: req_i request vector, ptr_i lowest-priority line, found_o, idx_o.
module pic_prio_resolve
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    localparam int IW = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               found_o,
    output logic [IW-1:0]      idx_o
);

    int best;
    int rk;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        best    = NUM_IRQ;
        rk      = 0;
        for (int j = 0; j < NUM_IRQ; j++) begin
            if (req_i[j]) begin
                rk = prio_rank(j, int'(ptr_i), NUM_IRQ);
                if (rk < best) begin
                    best    = rk;
                    found_o = 1'b1;
                    idx_o   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/pic_n.sv
// pic_n: parametrised programmable interrupt controller (IMR/IRR/ISR).
// Ports: clk, reset (async high), data_in/data_out register bus, select,
// wr, rd, IR request lines, intack, int_o, vector, vec_valid.
// Build option: PIC_ROTATE_EN enables rotating priority via OCR bit1.
module pic_n
    import pic_pkg::*;
#(
    parameter int         NUM_IRQ  = 8,
    parameter logic [7:0] VEC_BASE = 8'h20,
    parameter int         VEC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] data_in,
    output logic [NUM_IRQ-1:0] data_out,
    input  logic [1:0]         select,
    input  logic               wr,
    input  logic               rd,
    input  logic [NUM_IRQ-1:0] IR,
    input  logic               intack,
    output logic               int_o,
    output logic [VEC_W-1:0]   vector,
    output logic               vec_valid
);

    localparam int IW = $clog2(NUM_IRQ);
    localparam logic [IW-1:0] PTR_FIXED = IW'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] ir_s1_q, ir_s2_q, ir_prev_q, ir_edge;
    logic [NUM_IRQ-1:0] imr_q, imr_d, irr_q, irr_d, isr_q, isr_d;
    logic [NUM_IRQ-1:0] dout_q, dout_d, pend;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic               vec_valid_q, vec_valid_d;
    logic               int_q, win, ack_win;
    logic               wr_ocr, eoi, rot_w;
    logic               p_found, s_found;
    logic [IW-1:0]      p_idx, s_idx, ptr_eff;

    assign ir_edge = ir_s2_q & ~ir_prev_q;
    assign pend    = irr_q & ~imr_q;
    assign wr_ocr  = wr && (sel_e'(select) == SEL_OCR);
    assign eoi     = wr_ocr && data_in[OCR_EOI_BIT];

    pic_prio_resolve #(.NUM_IRQ(NUM_IRQ)) u_pend (
        .req_i   (pend),
        .ptr_i   (ptr_eff),
        .found_o (p_found),
        .idx_o   (p_idx)
    );

    pic_prio_resolve #(.NUM_IRQ(NUM_IRQ)) u_isr (
        .req_i   (isr_q),
        .ptr_i   (ptr_eff),
        .found_o (s_found),
        .idx_o   (s_idx)
    );

    // A pending line wins only if it outranks everything in service.
    assign win = p_found && (!s_found ||
        prio_rank(int'(p_idx), int'(ptr_eff), NUM_IRQ) <
        prio_rank(int'(s_idx), int'(ptr_eff), NUM_IRQ));
    assign ack_win = intack && win;

`ifdef PIC_ROTATE_EN
    logic          rot_q, rot_d;
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        rot_d = rot_q;
        ptr_d = ptr_q;
        if (wr_ocr) rot_d = data_in[OCR_ROT_BIT];
        // The line just retired drops to lowest priority.
        if (eoi && s_found && rot_d) ptr_d = s_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rot_q <= RST_ROT;
            ptr_q <= PTR_FIXED;
        end else begin
            rot_q <= rot_d;
            ptr_q <= ptr_d;
        end
    end

    assign rot_w   = rot_q;
    assign ptr_eff = rot_q ? ptr_q : PTR_FIXED;
`else
    assign rot_w   = 1'b0;
    assign ptr_eff = PTR_FIXED;
`endif

    always_comb begin
        imr_d       = imr_q;
        irr_d       = irr_q;
        isr_d       = isr_q;
        vector_d    = vector_q;
        vec_valid_d = 1'b0;
        dout_d      = dout_q;

        if (wr && (sel_e'(select) == SEL_IMR)) imr_d = data_in;

        if (ack_win) begin
            irr_d[p_idx] = 1'b0;
            isr_d[p_idx] = 1'b1;
        end
        // A fresh edge survives a same-cycle clear.
        irr_d = irr_d | ir_edge;

        // EOI acts on the old ISR, so a bit set this cycle is spared.
        if (eoi && s_found) isr_d[s_idx] = 1'b0;

        if (intack) begin
            vec_valid_d = 1'b1;
            vector_d    = ack_win
                ? VEC_W'(VEC_BASE) + VEC_W'(p_idx)
                : VEC_W'(VEC_BASE) + VEC_W'(NUM_IRQ - 1);
        end

        if (rd) begin
            unique case (sel_e'(select))
                SEL_OCR: begin
                    dout_d              = '0;
                    dout_d[OCR_ROT_BIT] = rot_w;
                end
                SEL_IMR: dout_d = imr_q;
                SEL_IRR: dout_d = irr_q;
                SEL_ISR: dout_d = isr_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_s1_q     <= '0;
            ir_s2_q     <= '0;
            ir_prev_q   <= '0;
            imr_q       <= {NUM_IRQ{RST_MASK}};
            irr_q       <= '0;
            isr_q       <= '0;
            int_q       <= RST_INT;
            vector_q    <= '0;
            vec_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            ir_s1_q     <= IR;
            ir_s2_q     <= ir_s1_q;
            ir_prev_q   <= ir_s2_q;
            imr_q       <= imr_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            int_q       <= win;
            vector_q    <= vector_d;
            vec_valid_q <= vec_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign int_o     = int_q;
    assign vector    = vector_q;
    assign vec_valid = vec_valid_q;
    assign data_out  = dout_q;

endmodule

// File: doc/pic_n.md
Name: pic_n

Overview:
- Parametrised programmable interrupt controller, next generation of the 8-line PIC.
- Accepts NUM_IRQ edge-triggered request lines and tracks them in three registers: IMR (mask), IRR (request) and ISR (in-service).
- Arbitrates by priority, raises int, and on intack returns the winning vector.
- Sits between peripheral IRQ sources and the CPU register bus; split read/write data replaces the old tristate bus.

Parameters:
- NUM_IRQ, 8, number of request lines; legal range 2..16. The data bus width equals NUM_IRQ.
- VEC_BASE, 8'h20, value added to the winning line index to form vector.
- VEC_W, 8, width of the vector output.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  NUM_IRQ  register write data.
- data_out  out  NUM_IRQ  register read data; registered.
- select  in  2  register select: SEL_OCR=0, SEL_IMR=1, SEL_IRR=2, SEL_ISR=3.
- wr  in  1  write strobe, one cycle; writes the register chosen by select.
- rd  in  1  read strobe; data_out is valid the cycle after rd.
- IR  in  NUM_IRQ  interrupt request lines, asynchronous to clk.
- intack  in  1  interrupt acknowledge, one-cycle pulse.
- int  out  1  interrupt to CPU, registered.
- vector  out  VEC_W  acknowledged vector; registered.
- vec_valid  out  1  one-cycle pulse marking vector as valid.

Behaviour:
- Reset values: IMR all ones (all lines masked); IRR=0; ISR=0; OCR=0; lowest-priority pointer = NUM_IRQ-1; int=0; vector=0; vec_valid=0; data_out=0.
- Reset is honoured mid-transaction; a pending ack is discarded.
- Synchroniser: IR passes through two flops. Edge = sync & ~prev.
- IRR update: an edge sets the IRR bit on the next clk. Latency is 3 clks from the first IR-high sample to IRR set, and 4 clks to int.
- Pending set: P = IRR & ~IMR.
- int rule: int<=1 when P is nonzero AND the highest-priority bit of P outranks every set ISR bit. Otherwise int<=0.
- Priority, fixed mode: line 0 is highest.
- Priority, rotate mode: the line after the pointer is highest, with wrap-around at NUM_IRQ-1 -> 0.
- intack (sampled at the clk edge) when P wins:
  - clear the IRR bit and set the ISR bit;
  - vector<=VEC_BASE+index, vec_valid<=1 for one cycle;
  - int drops the following cycle, unless a further request qualifies.
- Spurious intack (no winner): vector<=VEC_BASE+NUM_IRQ-1, vec_valid<=1, ISR unchanged.
- OCR write:
  - bit0 = non-specific EOI: clears the highest-priority set ISR bit; no-op if ISR=0.
  - bit1 = rotate mode enable; persists.
  - Bit0 self-clears; OCR reads return bit1 only.
- IMR write takes effect next cycle. IRR and ISR are read-only; writes to them are ignored.
- Simultaneous events:
  - An edge on the same line as a clearing intack leaves IRR set, so the new request is kept.
  - intack and an IMR write in the same cycle: arbitration uses the old IMR.
  - EOI and intack in the same cycle: the intack update is applied, then the EOI clears the highest ISR bit excluding the newly set one.
- Masking a line already in IRR leaves its IRR bit latched.

Optional Feature:
- Macro PIC_ROTATE_EN.
- Defined: rotate mode is available via OCR bit1. On EOI in rotate mode, the pointer <= the cleared line, so that line becomes lowest priority.
- Undefined: OCR bit1 is ignored and reads 0; priority is fixed (line 0 highest); the pointer logic is not built.

Decomposition:
- Shared package pic_pkg: SEL_OCR/SEL_IMR/SEL_IRR/SEL_ISR codes, OCR_EOI_BIT=0, OCR_ROT_BIT=1, reset constants.
- Sub-module pic_prio_resolve: combinational, parametrised by NUM_IRQ.
  - Inputs: request vector, pointer.
  - Outputs: found flag, winning index.
  - Used twice: once for the pending winner, once for the highest ISR bit on EOI.

Test Plan:
- Reset (NUM_IRQ=8): IMR reads 8'hFF, IRR/ISR read 0, int=0; pulse IR[3] -> int stays 0 and IRR reads 8'h08.
- IMR=8'h00, IR[5] then IR[2] raised together: int=1 at 4 clks; intack -> vector=8'h22, ISR=8'h04; EOI, intack -> vector=8'h25.
- IR[6] in service, then IR[1] edge -> int re-asserts (preemption); IR[7] edge while only IR[6] is in service -> int stays 0.
- intack with IRR=0 -> vector=VEC_BASE+7=8'h27, vec_valid=1, ISR unchanged.
- PIC_ROTATE_EN with OCR=2'b10:
  - service and EOI IR[0], then raise IR[0] and IR[4] -> the next vector is 8'h24;
  - rerun with the macro undefined -> the next vector is 8'h20.
- NUM_IRQ=16, VEC_BASE=8'h40: IR[15] edge with reset asserted mid-ack -> all registers at reset values; after release and unmask, intack -> vector=8'h4F.
